// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, address-width helper and zero-register index
// for the multi-port register file.
`default_nettype none

package rf_pkg;

  localparam int unsigned c_xlen_def = 32;
  localparam int unsigned c_nreg_def = 32;
  localparam int unsigned c_zero_idx = 0;

  function automatic int unsigned rf_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: issue/read/writeback bundle of the register file.
// Revision: 1.0
`default_nettype none

interface regfile_mp_sb_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = c_xlen_def,
  parameter int unsigned NREG = c_nreg_def,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = rf_clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits; issue sets, writeback clears.
// Revision: 1.0
`default_nettype none

module regfile_sb_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREG     = c_nreg_def,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = rf_clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  output logic [NREG-1:0]   o_busy_vec
);

  logic [NREG-1:0] w_clr;

  always_comb begin
    w_clr = '0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j]) w_clr[i_wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    if (ZERO_REG != 0 && i == c_zero_idx) begin : g_zero
      assign o_busy_vec[i] = 1'b0;
    end else begin : g_flop
      logic r_busy;
      // A new producer outranks a same-cycle writeback of the old one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_busy <= 1'b0;
        end else if (i_iss_en && i_iss_addr == AW'(i)) begin
          r_busy <= 1'b1;
        end else if (w_clr[i]) begin
          r_busy <= 1'b0;
        end
      end
      assign o_busy_vec[i] = r_busy;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-port register file with optional
// write-to-read bypass and busy scoreboard. Revision: 1.0
`default_nettype none

module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = c_xlen_def,
  parameter int unsigned NREG     = c_nreg_def,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_sb_if.slave bus
);

  localparam int unsigned AW = rf_clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] w_mem;
  logic [NREG-1:0]           w_busy_vec;
  logic [NRD*XLEN-1:0]       w_rd_data;
  logic [NRD-1:0]            w_rd_busy;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (ZERO_REG != 0 && i == c_zero_idx) begin : g_zero
      assign w_mem[i] = '0;
    end else begin : g_store
      logic [XLEN-1:0] r_q;
      // Ports are scanned in ascending order so the highest-index write lands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == AW'(i)) begin
              r_q <= bus.wr_data[j*XLEN +: XLEN];
            end
          end
        end
      end
      assign w_mem[i] = r_q;
    end
  end

  regfile_sb_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .o_busy_vec (w_busy_vec)
  );

  // Forwarding is suppressed under reset because the write will not land.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rd_data[k*XLEN +: XLEN] = w_mem[bus.rd_addr[k*AW +: AW]];
      w_rd_busy[k]              = w_busy_vec[bus.rd_addr[k*AW +: AW]];
      if (BYPASS != 0 && rst_n &&
          !(ZERO_REG != 0 && bus.rd_addr[k*AW +: AW] == AW'(c_zero_idx))) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[k*AW +: AW]) begin
            w_rd_data[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
            w_rd_busy[k]              = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_vec = w_busy_vec;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: randomized + directed bench with a queue scoreboard
// against an array model of the register file.
`default_nettype none

module tb_regfile_mp_sb;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  busy;
    logic [31:0] bvec;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  regfile_mp_sb_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp_sb #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      int          a;
      logic [31:0] d;
      logic        b;
      a = int'(bus.rd_addr[k*5 +: 5]);
      d = m_mem[a];
      b = m_busy[a];
      for (int j = 0; j < 2; j++) begin
        if (bus.wr_en[j] && int'(bus.wr_addr[j*5 +: 5]) == a) begin
          d = bus.wr_data[j*32 +: 32];
          b = 1'b0;
        end
      end
      if (a == 0 || !rst_n) begin
        d = '0;
        b = 1'b0;
      end
      e.data[k*32 +: 32] = d;
      e.busy[k]          = b;
    end
    for (int i = 0; i < 32; i++) e.bvec[i] = rst_n ? m_busy[i] : 1'b0;
    return e;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*5 +: 5] != 5'd0) begin
          m_mem[bus.wr_addr[j*5 +: 5]]  = bus.wr_data[j*32 +: 32];
          m_busy[bus.wr_addr[j*5 +: 5]] = 1'b0;
        end
      end
      if (bus.iss_en && bus.iss_addr != 5'd0) m_busy[bus.iss_addr] = 1'b1;
    end
  endtask

  task automatic step(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic iss, input logic [4:0] ia,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    bus.wr_en    = wen;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.iss_en   = iss;
    bus.iss_addr = ia;
    bus.rd_addr  = {ra1, ra0};
    q.push_back(predict());
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1);
    step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (bus.rd_data[k*32 +: 32] !== e.data[k*32 +: 32]) begin
            errors++;
            $display("FAIL rd_data[%0d] addr=%0d got=%h exp=%h", k, bus.rd_addr[k*5 +: 5],
                     bus.rd_data[k*32 +: 32], e.data[k*32 +: 32]);
          end
          checks++;
          if (bus.rd_busy[k] !== e.busy[k]) begin
            errors++;
            $display("FAIL rd_busy[%0d] addr=%0d got=%b exp=%b", k, bus.rd_addr[k*5 +: 5],
                     bus.rd_busy[k], e.busy[k]);
          end
        end
        checks++;
        if (bus.busy_vec !== e.bvec) begin
          errors++;
          $display("FAIL busy_vec got=%h exp=%h", bus.busy_vec, e.bvec);
        end
      end
    end
  end

  initial begin : driver
    int waited;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0; bus.rd_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rd(5'd0, 5'd0);
    rd(5'd1, 5'd2);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) rd(5'(a), 5'(31 - a));

    step(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    rd(5'd5, 5'd5);
    step(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd5);
    rd(5'd0, 5'd0);

    step(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    rd(5'd7, 5'd0);

    step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd1);
    rd(5'd9, 5'd9);
    step(2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd2);
    rd(5'd9, 5'd9);

    step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
    step(2'b01, 5'd4, 32'hAA, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd3);
    rd(5'd4, 5'd4);
    step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd4);
    rd(5'd0, 5'd0);

    // Asynchronous reset with an issue and a write pending on r3.
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd3}; bus.wr_data = {32'd0, 32'h77};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3; bus.rd_addr = {5'd3, 5'd3};
    #1;
    rst_n = 1'b0;
    q.push_back(predict());
    model_update();
    @(posedge clk);
    #1;
    rd(5'd3, 5'd4);
    rst_n = 1'b1;
    rd(5'd3, 5'd9);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] a[6];
      for (int i = 0; i < 6; i++)
        a[i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      step(2'($urandom_range(0, 3)), a[0], $urandom(), a[1], $urandom(),
           1'($urandom_range(0, 1)), a[2], a[3], a[4]);
    end
    rd(5'd0, 5'd1);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the next-generation RISC core.
- Replaces the fixed 2-read/1-write file.
- Generalised in width, depth, read-port count and write-port count.
- Adds optional write-to-read bypass and a per-register busy scoreboard for issue/writeback hazard tracking.
- Sits between the decode/issue stage (reads, busy marking) and the writeback stage (writes, busy clearing).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; power of 2, at least 2
AW, $clog2(NREG), register address width; derived, not overridden
NRD, 2, number of read ports, 1..4
NWR, 2, number of write ports, 1..2
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data; port k uses [k*XLEN +: XLEN]
rd_busy  out  NRD  busy flag of each addressed register
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
iss_en  in  1  issue strobe: mark iss_addr busy
iss_addr  in  AW  destination register being issued
busy_vec  out  NREG  full scoreboard, bit i = register i busy

Behaviour:
Reset (rst_n low, asynchronous):
- All registers clear to 0. No preset test values.
- All busy bits clear. Therefore busy_vec = 0, rd_busy = 0, rd_data = 0.
- Reset asserted mid-operation discards any in-flight write or issue on that edge.

Writes (synchronous):
- Port j writes on the rising edge when wr_en[j]=1.
- With ZERO_REG=1, writes to address 0 are ignored.
- Two ports to the same address in one cycle: the higher-index port wins, and the lower-index write is dropped.

Reads (combinational, zero latency):
- rd_data[k] = stored value of rd_addr[k].
- With ZERO_REG=1, address 0 always reads 0.
- With BYPASS=1: if any enabled write port targets rd_addr[k] this cycle (and the address is not the zeroed register 0), rd_data[k] = that wr_data.
  - The highest-index matching port supplies the data.
- With BYPASS=0: the new value is visible the cycle after the write edge.

Scoreboard:
- Per-register busy bit.
- Next state for register i, in priority order:
  - iss_en and iss_addr==i → set. A new producer overrides a same-cycle writeback, so issue wins over clear.
  - otherwise any wr_en[j] with wr_addr[j]==i → clear.
  - otherwise hold.
- With ZERO_REG=1, busy[0] is constant 0 and issue to address 0 is ignored.
- rd_busy[k] = busy[rd_addr[k]], except when BYPASS=1 and the register is written this cycle.
  - In that case rd_busy[k]=0, because the data is valid via bypass.
- busy_vec is registered state only (no bypass masking).
- Issue to an already-busy register: stays busy (WAW allowed; the team's pipeline orders writebacks).

Widths and combinational paths:
- No arithmetic; all paths are exact-width.
- No combinational path from iss_* to any output.

Decomposition:
Shared package rf_pkg:
- Default XLEN/NREG constants.
- A clog2 function for AW.
- A localparam for the zero-register index.

One sub-module, regfile_sb_scoreboard:
- Holds the busy bits, set/clear priority logic and busy_vec.
- Parameters NREG, NWR, ZERO_REG.

Data array, write priority and bypass muxing stay in the top module.

Test Plan:
1. Reset, then read all addresses on both ports → rd_data=0, rd_busy=0, busy_vec=0.
2. wr_en=2'b01, addr 5, data 0xDEADBEEF; next cycle read r5 → 0xDEADBEEF. Write r0=0x1234 → r0 reads 0.
3. Both ports write r7 in the same cycle (port0 0x11, port1 0x22) → r7=0x22. Same cycle with BYPASS=1, read r7 → 0x22 combinationally. BYPASS=0 build → old value until the next cycle.
4. iss_en r9 → busy_vec[9]=1 next cycle, rd_busy=1 when reading r9. Writeback r9=0x55 → rd_busy=0 in the same cycle (bypass), busy_vec[9]=0 next cycle.
5. Same cycle: iss_en r4 and wr_en r4 (busy previously set) → busy_vec[4] remains 1 and r4 gets the write data. iss_en r0 → busy_vec[0] stays 0.
6. Issue r3 and write r3 pending, assert rst_n low mid-cycle → all outputs 0 immediately. After release, r3=0 and busy_vec=0.
